fm_mult_scheduler: RTL and testbench

FM_MULT_SCHEDULER -- requirements
Module: fm_mult_scheduler

---
 rtl/fm_mult_scheduler_pkg.sv | 29 ++
 rtl/seqmultNM.sv | 65 ++++++
 rtl/fm_mult_scheduler.sv | 149 ++++++++++++++
 tb/tb_fm_mult_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fm_mult_scheduler_pkg.sv
// Shared constants for the FM multiplex scheduler: FSM encoding, multiplier
// geometry, scaling shifts and sample widths.
package fm_mult_scheduler_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    MUL_M  = 4'd1,
    WAIT_M = 4'd2,
    MUL_R  = 4'd3,
    WAIT_R = 4'd4,
    SUM    = 4'd5,
    MUL_F  = 4'd6,
    WAIT_F = 4'd7,
    OUT    = 4'd8
  } state_t;

  localparam int MUL_A_W   = 20;
  localparam int MUL_B_W   = 9;
  localparam int MUL_P_W   = 29;

  localparam int PILOT_SHR = 3;
  localparam int PILOT_SHL = 5;
  localparam int SUB_SHR   = 8;
  localparam int FINAL_SHR = 5;

  localparam int SAMPLE_W  = 18;
  localparam int OUT_W     = 24;

endpackage

// File: rtl/seqmultNM.sv
// Sequential signed MxN shift-add multiplier. ready drops the cycle after
// start and returns high with R valid N+1 cycles after the start edge.
module seqmultNM #(
  parameter int M = 20,
  parameter int N = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [M-1:0]   A,
  input  logic signed [N-1:0]   B,
  output logic signed [M+N-1:0] R,
  output logic                  ready
);

  localparam int W  = M + N;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic signed [W-1:0] r_acc;
  logic signed [W-1:0] r_a;
  logic        [N-1:0] r_b;
  logic       [CW-1:0] r_cnt;
  logic signed [W-1:0] r_prod;
  logic                r_ready;
  logic signed [W-1:0] w_addend;
  logic signed [W-1:0] w_acc_next;

  // The multiplier MSB carries negative weight, so the last partial product subtracts.
  always_comb begin
    w_addend = '0;
    if (r_b[0]) w_addend = (r_cnt == LAST) ? -r_a : r_a;
    w_acc_next = r_acc + w_addend;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_ready <= 1'b1;
    end else if (start) begin
      r_acc   <= '0;
      r_a     <= {{N{A[M-1]}}, A};
      r_b     <= B;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (!r_ready) begin
      r_acc <= w_acc_next;
      r_a   <= r_a <<< 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_prod  <= w_acc_next;
        r_ready <= 1'b1;
      end
    end
  end

  assign R     = r_prod;
  assign ready = r_ready;

endmodule

// File: rtl/fm_mult_scheduler.sv
// Stereo FM multiplex builder: pilot, subcarrier and deviation products share
// one sequential multiplier, scheduled by a single FSM per 192 kHz sample.
module fm_mult_scheduler
  import fm_mult_scheduler_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clken_192,
  input  logic signed [SAMPLE_W-1:0] LI_LEFT,
  input  logic signed [SAMPLE_W-1:0] LI_RIGHT,
  input  logic signed [7:0]          sine_19,
  input  logic signed [7:0]          sine_38,
  input  logic        [3:0]          Kp,
  input  logic        [7:0]          Kf,
  output logic signed [OUT_W-1:0]    FMout,
  output logic                       ready_block_192,
  output logic                       busy,
  output logic                       overrun
);

  state_t                      r_state;
  logic signed [SAMPLE_W-1:0]  r_left, r_right;
  logic signed [7:0]           r_s19, r_s38;
  logic        [3:0]           r_kp;
  logic        [7:0]           r_kf;
  logic signed [SAMPLE_W-1:0]  r_term_m, r_term_r;
  logic signed [MUL_A_W-1:0]   r_sum;
  logic signed [OUT_W-1:0]     r_final, r_fmout;
  logic                        r_ready_blk, r_overrun, r_start;
  logic signed [MUL_A_W-1:0]   w_a;
  logic signed [MUL_B_W-1:0]   w_b;
  logic signed [MUL_P_W-1:0]   w_p;
  logic                        w_mul_ready;

  function automatic logic signed [SAMPLE_W-1:0] scale_pilot(input logic signed [MUL_P_W-1:0] p);
    return SAMPLE_W'((p >>> PILOT_SHR) <<< PILOT_SHL);
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] scale_sub(input logic signed [MUL_P_W-1:0] p);
    return SAMPLE_W'(p >>> SUB_SHR);
  endfunction

  function automatic logic signed [OUT_W-1:0] scale_final(input logic signed [MUL_P_W-1:0] p);
    return OUT_W'(p >>> FINAL_SHR);
  endfunction

  // Operands stay selected through WAIT_x so they are stable while the multiplier runs.
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      MUL_M, WAIT_M: begin
        w_a = {{(MUL_A_W-8){r_s19[7]}}, r_s19};
        w_b = {{(MUL_B_W-4){1'b0}}, r_kp};
      end
      MUL_R, WAIT_R: begin
        w_a = {{(MUL_A_W-SAMPLE_W){r_right[SAMPLE_W-1]}}, r_right};
        w_b = {r_s38[7], r_s38};
      end
      MUL_F, WAIT_F: begin
        w_a = r_sum;
        w_b = {1'b0, r_kf};
      end
      default: ;
    endcase
  end

  seqmultNM #(.M(MUL_A_W), .N(MUL_B_W)) u_mult (
    .clock (clock),
    .reset (reset),
    .start (r_start),
    .A     (w_a),
    .B     (w_b),
    .R     (w_p),
    .ready (w_mul_ready)
  );

  // start is raised on entry to each MUL_x so the multiplier has dropped ready by WAIT_x.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_left      <= '0;
      r_right     <= '0;
      r_s19       <= '0;
      r_s38       <= '0;
      r_kp        <= '0;
      r_kf        <= '0;
      r_term_m    <= '0;
      r_term_r    <= '0;
      r_sum       <= '0;
      r_final     <= '0;
      r_fmout     <= '0;
      r_ready_blk <= 1'b0;
      r_overrun   <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_ready_blk <= 1'b0;
      if (clken_192 && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (clken_192) begin
          r_left  <= LI_LEFT;
          r_right <= LI_RIGHT;
          r_s19   <= sine_19;
          r_s38   <= sine_38;
          r_kp    <= Kp;
          r_kf    <= Kf;
          r_start <= 1'b1;
          r_state <= MUL_M;
        end
        MUL_M:  r_state <= WAIT_M;
        WAIT_M: if (w_mul_ready) begin
          r_term_m <= scale_pilot(w_p);
          r_start  <= 1'b1;
          r_state  <= MUL_R;
        end
        MUL_R:  r_state <= WAIT_R;
        WAIT_R: if (w_mul_ready) begin
          r_term_r <= scale_sub(w_p);
          r_state  <= SUM;
        end
        SUM: begin
          r_sum   <= {{(MUL_A_W-SAMPLE_W){r_left[SAMPLE_W-1]}}, r_left}
                   + {{(MUL_A_W-SAMPLE_W){r_term_m[SAMPLE_W-1]}}, r_term_m}
                   + {{(MUL_A_W-SAMPLE_W){r_term_r[SAMPLE_W-1]}}, r_term_r};
          r_start <= 1'b1;
          r_state <= MUL_F;
        end
        MUL_F:  r_state <= WAIT_F;
        WAIT_F: if (w_mul_ready) begin
          r_final <= scale_final(w_p);
          r_state <= OUT;
        end
        OUT: begin
          r_fmout     <= r_final;
          r_ready_blk <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FMout           = r_fmout;
  assign ready_block_192 = r_ready_blk;
  assign busy            = (r_state != IDLE);
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_fm_mult_scheduler.sv
// Directed self-checking bench for fm_mult_scheduler.
module tb_fm_mult_scheduler;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clken_192 = 1'b0;
  logic signed [17:0] LI_LEFT = '0;
  logic signed [17:0] LI_RIGHT = '0;
  logic signed [7:0]  sine_19 = '0;
  logic signed [7:0]  sine_38 = '0;
  logic        [3:0]  Kp = '0;
  logic        [7:0]  Kf = '0;
  logic signed [23:0] FMout;
  logic               ready_block_192;
  logic               busy;
  logic               overrun;

  int n_total = 0;
  int n_bad   = 0;

  // Strobe edge to ready pulse: three multiplies of N+1 = 10 cycles plus 5.
  localparam int LATENCY = 35;

  fm_mult_scheduler dut (
    .clock           (clock),
    .reset           (reset),
    .clken_192       (clken_192),
    .LI_LEFT         (LI_LEFT),
    .LI_RIGHT        (LI_RIGHT),
    .sine_19         (sine_19),
    .sine_38         (sine_38),
    .Kp              (Kp),
    .Kf              (Kf),
    .FMout           (FMout),
    .ready_block_192 (ready_block_192),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input int l, input int r, input int s19, input int s38,
                            input int kp, input int kf);
    LI_LEFT  = 18'(l);
    LI_RIGHT = 18'(r);
    sine_19  = 8'(s19);
    sine_38  = 8'(s38);
    Kp       = 4'(kp);
    Kf       = 8'(kf);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One strobe, then watch a bounded window for ready pulses.
  task automatic do_sample(input int l, input int r, input int s19, input int s38,
                           input int kp, input int kf,
                           output int lat, output int pulses, output int fm);
    @(negedge clock);
    set_inputs(l, r, s19, s38, kp, kf);
    clken_192 = 1'b1;
    @(negedge clock);
    clken_192 = 1'b0;
    lat = -1;
    pulses = 0;
    fm = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clock);
      if (ready_block_192) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          fm  = int'(FMout);
        end
      end
    end
  endtask

  task automatic run_vec(input string tag, input int l, input int r, input int s19,
                         input int s38, input int kp, input int kf, input int exp_fm);
    int lat, pulses, fm;
    do_sample(l, r, s19, s38, kp, kf, lat, pulses, fm);
    chk({tag, "_fm"}, fm, exp_fm);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_hold"}, int'(FMout), exp_fm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, pulses, fm;

    repeat (3) @(negedge clock);
    chk("rst_fmout", int'(FMout), 0);
    chk("rst_ready", int'(ready_block_192), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    do_sample(1000, 0, 0, 0, 0, 32, lat, pulses, fm);
    chk("basic_fm", fm, 1000);
    chk("basic_lat", lat, LATENCY);
    chk("basic_pulses", pulses, 1);
    chk("basic_busy", int'(busy), 0);
    chk("basic_overrun", int'(overrun), 0);

    run_vec("pilot", 0, 0, 127, 0, 8, 32, 4064);
    run_vec("sub", 0, 1024, 0, -128, 0, 32, -512);
    chk("sub_hex", int'(FMout[23:0]), 24'hFFFE00);
    run_vec("pilot_neg", 0, 0, -128, 0, 15, 32, -7680);
    run_vec("sub_floor", 0, 1, 0, -1, 0, 32, -1);
    run_vec("final_floor", -1, 0, 0, 0, 0, 1, -1);
    run_vec("left_neg", -1000, 0, 0, 0, 0, 16, -500);
    run_vec("worst", 131071, 131071, 127, 127, 15, 255, 1623314);
    chk("no_overrun_yet", int'(overrun), 0);

    // Second strobe 3 cycles into the first sample.
    @(negedge clock);
    set_inputs(1000, 0, 0, 0, 0, 32);
    clken_192 = 1'b1;
    @(negedge clock);
    clken_192 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    set_inputs(5000, 0, 0, 0, 0, 32);
    clken_192 = 1'b1;
    @(negedge clock);
    clken_192 = 1'b0;
    chk("ovr_flag", int'(overrun), 1);
    pulses = 0;
    fm = 0;
    for (int i = 4; i <= 50; i++) begin
      @(negedge clock);
      if (ready_block_192) begin
        pulses++;
        fm = int'(FMout);
      end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_fm", fm, 1000);
    chk("ovr_sticky", int'(overrun), 1);

    do_reset();
    chk("ovr_cleared", int'(overrun), 0);

    // Strobe landing on the OUT cycle is dropped and flagged.
    @(negedge clock);
    set_inputs(0, 0, 127, 0, 8, 32);
    clken_192 = 1'b1;
    @(negedge clock);
    clken_192 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      clken_192 = (i == LATENCY - 1);
      if (ready_block_192) pulses++;
    end
    clken_192 = 1'b0;
    chk("out_ovr_flag", int'(overrun), 1);
    chk("out_ovr_pulses", pulses, 1);
    chk("out_ovr_busy", int'(busy), 0);
    chk("out_ovr_fm", int'(FMout), 4064);

    // Reset while the subcarrier multiply is in progress.
    @(negedge clock);
    set_inputs(1000, 0, 0, 0, 0, 32);
    clken_192 = 1'b1;
    @(negedge clock);
    clken_192 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (ready_block_192) pulses++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_fmout", int'(FMout), 0);
    chk("abort_overrun", int'(overrun), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready_block_192) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    do_sample(1000, 0, 0, 0, 0, 32, lat, pulses, fm);
    chk("after_abort_fm", fm, 1000);
    chk("after_abort_lat", lat, LATENCY);
    chk("after_abort_pulses", pulses, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
